// File: rtl/mips_input_fifo.sv
// Purpose: synchronous show-ahead input FIFO with a sticky overflow flag.
// Latency: a written word shows on data_out the cycle after its accepting edge.
// Backpressure: none upstream; writes that arrive while full with no pop are dropped and flagged.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst      - synchronous active-high reset (head, tail, count, overflow)
//   wr_en    - write request for data_in
//   data_in  - word to store (DATA_WIDTH bits)
//   rd_en    - pop request for the head entry (ignored while empty)
//   ovf_clr  - clears the sticky overflow flag (a same-edge drop wins)
//   data_out - head entry while valid, zero otherwise
//   valid    - FIFO non-empty
//   full     - count equals DEPTH
//   count    - entries held, 0..DEPTH
//   overflow - sticky, set when a write was dropped
module mips_input_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  input  logic                       ovf_clr,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic do_pop;
  logic do_wr;
  logic drop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop only happens when there is something to pop; a write is accepted
  // when there is room, or when a same-edge pop frees the slot (only possible
  // while full, where valid is necessarily 1).
  assign do_pop = rd_en & valid;
  assign do_wr  = wr_en & (~full | rd_en);
  assign drop   = wr_en & full & ~rd_en;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    if (do_pop) head_d = head_q + AW'(1);
    if (do_wr)  tail_d = tail_q + AW'(1);

    if (do_wr && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_wr) count_d = count_q - CW'(1);

    // Set has priority over clear so a drop on the clearing edge is not lost.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries no reset; entries are only observable through valid.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem_q[tail_q] <= data_in;
  end

  assign data_out = valid ? mem_q[head_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: doc/mips_input_fifo.md
MIPS_INPUT_FIFO -- requirements
Module: mips_input_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of each input word.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of entries; legal values are powers of two, 2 to 256.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request for data_in.
REQ-006 The block SHALL have port data_in, input, DATA_WIDTH bits: word to store.
REQ-007 The block SHALL have port rd_en, input, 1 bit: pop request for the head entry.
REQ-008 The block SHALL have port ovf_clr, input, 1 bit: clears the overflow flag.
REQ-009 The block SHALL have port data_out, output, DATA_WIDTH bits: head entry (show-ahead).
REQ-010 The block SHALL have port valid, output, 1 bit: FIFO non-empty; data_out meaningful.
REQ-011 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1 bits: entries held, 0..DEPTH.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, a write was dropped.

Function
REQ-014 The block SHALL accept a write on a clk edge when wr_en=1 and (full=0 or rd_en=1); accepted data is stored at the tail entry and the tail pointer increments.
REQ-015 The block SHALL perform a pop on a clk edge when rd_en=1 and valid=1; the head pointer increments and the popped word is discarded.
REQ-016 The block SHALL ignore rd_en when valid=0: no pointer change, no flag change.
REQ-017 The block SHALL drop a write when wr_en=1, full=1 and rd_en=0: storage and count are unchanged and overflow is set to 1 on that edge.
REQ-018 The block SHALL, when full with wr_en=1 and rd_en=1, pop the head and accept the write in the same edge; count stays at DEPTH and overflow is not set.
REQ-019 The block SHALL, when empty with wr_en=1 and rd_en=1, accept the write and ignore the read; count becomes 1.
REQ-020 The block SHALL update count as +1 on write-only, -1 on pop-only, and unchanged on both or neither.
REQ-021 The block SHALL wrap head and tail pointers modulo DEPTH with no gap or lost entry.
REQ-022 The block SHALL drive data_out combinationally from the head entry when valid=1 and all zeros when valid=0.
REQ-023 The block SHALL expose a written word on data_out in the cycle after its accepting edge (one-cycle write-to-read latency); there is no fall-through in the same cycle.
REQ-024 The block SHALL derive valid as (count != 0) and full as (count == DEPTH), both from registered count.
REQ-025 The block SHALL keep overflow at 1 until ovf_clr=1 on an edge; if ovf_clr=1 and a drop (REQ-017) occur on the same edge, overflow SHALL be 1 (set wins).
REQ-026 The block SHALL preserve word order: words leave in exactly the order they were accepted.

Reset
REQ-027 The block SHALL, on any clk edge with rst=1, set head=0, tail=0, count=0 and overflow=0, giving data_out=0, valid=0 and full=0 in the following cycle.
REQ-028 The block SHALL give rst priority over wr_en, rd_en and ovf_clr on the same edge; these inputs are ignored.
REQ-029 The block SHALL discard all held entries on reset mid-operation; storage array contents need not be cleared.
REQ-030 The block SHALL NOT reset asynchronously: a rst pulse that does not span a rising clk edge has no effect.

Verification
REQ-031 The bench SHALL cover basic order (DATA_WIDTH=8, DEPTH=4): write 0x11, 0x22, 0x33 on consecutive edges, then 3 pops -> data_out 0x11, 0x22, 0x33 in turn; count 3->2->1->0; valid=0 at end.
REQ-032 The bench SHALL cover fill and overflow: 4 writes 0xA0..0xA3 -> full=1, count=4; a 5th write 0xFF with rd_en=0 -> overflow=1, 4 pops return 0xA0..0xA3 only.
REQ-033 The bench SHALL cover full simultaneous read/write: when full, wr_en=1 with 0xB0 and rd_en=1 -> head 0xA0 removed, count=4, overflow unchanged, and 0xB0 emerges after 0xA3.
REQ-034 The bench SHALL cover empty corner cases: when empty, rd_en=1 alone -> no change; wr_en=1 with 0x5A and rd_en=1 -> count=1 and data_out=0x5A next cycle.
REQ-035 The bench SHALL cover wrap-around: 10 interleaved write/pop pairs with values 0x00..0x09 and DEPTH=4 -> every value returned in order, count never exceeds 4.
REQ-036 The bench SHALL cover reset and clear: rst=1 for one edge while holding 3 entries with overflow=1 -> count=0, valid=0, overflow=0, data_out=0x00; separately, ovf_clr=1 coinciding with a dropped write -> overflow stays 1.
